uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver types, default rates and bit-timing helper.
// UART_RX_PARITY_EN adds the even-parity PARITY state.
package uart_pkg;

  localparam int CLK_HZ_DEF = 12_000_000;
  localparam int BAUD_DEF   = 115_200;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  function automatic int bit_cyc(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input.
// Resets to 1 so an idle serial line shows no false edge.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 with valid/ready output and error pulses.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int BAUD   = BAUD_DEF
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  input  logic       uart_ready_i,
  output logic       uart_busy,
  output logic       uart_ferr_o,
  output logic       uart_ovr_o,
  output logic       uart_perr_o
);

  localparam int BIT_CYC  = bit_cyc(CLK_HZ, BAUD);
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CW       = $clog2(BIT_CYC + 1);

  localparam logic [CW-1:0] BIT_LD  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF_CYC - 1);

  logic          w_rx;
  logic          r_prev;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_nxt;
  logic          w_tick;
  logic          w_stop_ok;
  logic          w_stop_bad;
  logic          w_good;
  logic [7:0]    r_dat;
  logic          r_valid;
  logic          r_ferr;
  logic          r_ovr;
  logic          r_perr;

  sync_2ff u_sync (
    .i_clk (sys_clk_i),
    .i_rst (sys_rst_i),
    .i_d   (uart_rx_i),
    .o_q   (w_rx)
  );

  assign w_tick = (r_cnt == '0);

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic w_par_bad_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_tick ? r_cnt : r_cnt - 1'b1;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
`endif
    unique case (r_state)
      IDLE: begin
        if (r_prev && !w_rx) begin
          w_state_nxt = START;
          w_cnt_nxt   = HALF_LD;
        end
      end
      START: begin
        if (w_tick) begin
          if (w_rx) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
            w_cnt_nxt   = BIT_LD;
            w_idx_nxt   = 3'd0;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_cnt_nxt   = BIT_LD;
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          w_par_bad_nxt = ^{r_shift, w_rx};
          w_cnt_nxt     = BIT_LD;
          w_state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        if (w_tick) begin
          if (w_rx) begin
            w_stop_ok   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (w_rx) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_prev  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_prev  <= w_rx;
    end
  end

`ifdef UART_RX_PARITY_EN
  assign w_good = w_stop_ok && !r_par_bad;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_par_bad <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_par_bad <= w_par_bad_nxt;
      r_perr    <= w_stop_ok && r_par_bad;
    end
  end
`else
  assign w_good = w_stop_ok;

  always_ff @(posedge sys_clk_i) begin
    r_perr <= 1'b0;
  end
`endif

  // A byte still held unaccepted wins over a newly received one.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_dat   <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_stop_bad;
      r_ovr  <= 1'b0;
      if (w_good) begin
        if (!r_valid || uart_ready_i) begin
          r_dat   <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && uart_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign uart_dat_o   = r_dat;
  assign uart_valid_o = r_valid;
  assign uart_busy    = (r_state != IDLE);
  assign uart_ferr_o  = r_ferr;
  assign uart_ovr_o   = r_ovr;
  assign uart_perr_o  = r_perr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a received-byte scoreboard.
// Parity cases are built in when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int BIT = 104;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ready;
  logic [7:0] dat;
  logic       valid;
  logic       busy;
  logic       ferr;
  logic       ovr;
  logic       perr;

  int checks = 0;
  int errors = 0;

  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int perr_cnt = 0;
  int vcyc     = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  int f0, o0, p0, v0;

`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_rx dut (
    .sys_clk_i    (clk),
    .sys_rst_i    (rst),
    .uart_rx_i    (rx),
    .uart_dat_o   (dat),
    .uart_valid_o (valid),
    .uart_ready_i (ready),
    .uart_busy    (busy),
    .uart_ferr_o  (ferr),
    .uart_ovr_o   (ovr),
    .uart_perr_o  (perr)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) vcyc++;
      if (valid && ready) got_q.push_back(dat);
      if (ferr) ferr_cnt++;
      if (ovr) ovr_cnt++;
      if (perr) perr_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(
    input string tag,
    input int    obs,
    input int    exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag);
    chk({tag, "_count"}, got_q.size(), 1);
    if (got_q.size() > 0 && exp_q.size() > 0)
      chk(tag, got_q.pop_front(), exp_q.pop_front());
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(BIT);
  endtask

  task automatic send_frame(
    input logic [7:0] d,
    input logic       stop
  );
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d ^ par_flip);
`endif
    send_bit(stop);
  endtask

  task automatic snap();
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    p0 = perr_cnt;
    v0 = vcyc;
  endtask

  initial begin
    rst   = 1'b1;
    rx    = 1'b1;
    ready = 1'b1;
    tick(5);
    chk("rst_dat", dat, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {ferr, ovr, perr}, 0);
    rst = 1'b0;
    tick(10);

    snap();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(20);
    chk_byte("a5_data");
    chk("a5_valid_cycles", vcyc - v0, 1);
    chk("a5_errs", (ferr_cnt - f0) + (ovr_cnt - o0) + (perr_cnt - p0), 0);

    snap();
    rx = 1'b0;
    tick(40);
    rx = 1'b1;
    tick(200);
    chk("glitch_valid", vcyc - v0, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_busy", busy, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    tick(20);
    chk_byte("3c_data");

    snap();
    send_frame(8'h81, 1'b0);
    tick(500);
    chk("brk_ferr", ferr_cnt - f0, 1);
    chk("brk_valid", vcyc - v0, 0);
    chk("brk_busy", busy, 1);
    chk("brk_got", got_q.size(), 0);
    rx = 1'b1;
    tick(10);
    chk("brk_exit", busy, 0);
    tick(200);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    tick(20);
    chk_byte("55_data");
    chk("55_ferr", ferr_cnt - f0, 1);

    snap();
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(50);
    chk("ovr_dat", dat, 8'h11);
    chk("ovr_valid", valid, 1);
    chk("ovr_pulse", ovr_cnt - o0, 1);
    ready = 1'b1;
    tick(3);
    chk("ovr_clear", valid, 0);
    chk_byte("ovr_data");

    snap();
    rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b1;
    tick(50);
    rst = 1'b1;
    tick(3);
    chk("mrst_dat", dat, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_busy", busy, 0);
    rst = 1'b0;
    tick(300);
    chk("mrst_idle", vcyc - v0, 0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    tick(20);
    chk_byte("0f_data");
    chk("0f_valid_cycles", vcyc - v0, 1);

`ifdef UART_RX_PARITY_EN
    snap();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    tick(20);
    chk("par_perr", perr_cnt - p0, 1);
    chk("par_novalid", vcyc - v0, 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    tick(20);
    chk_byte("par_data");
    chk("par_perr_once", perr_cnt - p0, 1);
`endif

    chk("left_exp", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
